// File: rtl/descrambler_parallel_if.sv
// rtl/descrambler_parallel_if.sv - 66-bit block stream bundle in and out of the descrambler
interface descrambler_parallel_if;
  logic [65:0] data_in;
  logic        data_in_valid;
  logic [65:0] data_out;
  logic        data_out_valid;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid
  );
endinterface

// File: rtl/descrambler_parallel.sv
// rtl/descrambler_parallel.sv - 64b/66b parallel descrambler (1 + x^39 + x^58), header check; invalid-header counter built only under DESCRAM_ERR_CNT_EN
module descrambler_parallel #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  descrambler_parallel_if.slave link,
  input  logic                 bypass_enable,
  input  logic                 err_clear,
  output logic                 primed,
  output logic                 header_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [57:0]  s;
  logic [57:0]  s_next;
  logic [121:0] ext;
  logic [63:0]  r;
  logic [63:0]  d;
  logic         hdr_bad;
  logic [65:0]  dout_q;
  logic         dout_valid_q;

  assign r       = link.data_in[65:2];
  assign hdr_bad = (link.data_in[1:0] == 2'b00) || (link.data_in[1:0] == 2'b11);

  // ext[58+j] is line bit j of the stream (negative j reaches into the stored history)
  always_comb begin
    ext = '0;
    for (int k = 0; k < 58; k++) ext[k] = s[57-k];
    ext[121:58] = r;
    d = '0;
    for (int i = 0; i < 64; i++) d[i] = ext[58+i] ^ ext[19+i] ^ ext[i];
    s_next = '0;
    for (int k = 0; k < 58; k++) s_next[k] = r[63-k];
  end

  // Output block, header check and scrambled-history tracking (tracked even in bypass)
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q       <= {64'b0, 2'b10};
      dout_valid_q <= 1'b0;
      primed       <= 1'b0;
      header_err   <= 1'b0;
      s            <= '1;
    end else begin
      dout_valid_q <= link.data_in_valid;
      header_err   <= link.data_in_valid & hdr_bad;
      if (link.data_in_valid) begin
        dout_q <= {(bypass_enable ? r : d), link.data_in[1:0]};
        s      <= s_next;
        primed <= 1'b1;
      end
    end
  end

  assign link.data_out       = dout_q;
  assign link.data_out_valid = dout_valid_q;

`ifdef DESCRAM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_q;

  // Saturating invalid-header count; clear wins over a same-cycle error
  always_ff @(posedge clock) begin
    if (reset || err_clear) begin
      err_q <= '0;
    end else if (link.data_in_valid && hdr_bad && (err_q != {ERR_CNT_W{1'b1}})) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign err_count        = '0;
`endif

endmodule

// File: doc/descrambler_parallel.md
Name: descrambler_parallel

Overview:
Receive-side partner of the 64b/66b parallel scrambler. It descrambles one 66-bit block per clock using the self-synchronising polynomial 1 + x^39 + x^58. The 2-bit sync header passes through intact. The block sits between the block-lock/gearbox stage and the 64b/66b decoder, and also validates sync headers and counts invalid ones.

Parameters:
ERR_CNT_W, 8, width of the saturating invalid-header counter (range 2..16)

Ports:
clock  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
data_in  input  66  [65:2] scrambled payload (bit 2 = first bit on the line), [1:0] sync header
data_in_valid  input  1  block present on data_in this cycle
bypass_enable  input  1  1 = payload passed through unscrambled
err_clear  input  1  synchronous clear of err_count
data_out  output  66  [65:2] descrambled payload, [1:0] sync header (copied unchanged)
data_out_valid  output  1  data_out holds a newly produced block
primed  output  1  descrambler state has been loaded from received data
header_err  output  1  one-cycle pulse: the accepted block had header 2'b00 or 2'b11
err_count  output  ERR_CNT_W  saturating count of invalid headers

Behaviour:
- Reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values:
  - data_out = {64'b0, 2'b10}
  - data_out_valid = 0, primed = 0, header_err = 0, err_count = 0
  - internal state s[57:0] = all ones
- Notation: let r[i] = data_in[i+2] for i = 0..63. Let S(j) = r[j] for j >= 0, and S(j) = s[-j-1] for j < 0. So s[0] is the most recently received bit and s[57] the oldest.
- Descramble: d[i] = r[i] ^ S(i-39) ^ S(i-58), for i = 0..63. This is purely combinational from r and s.
- Accepted block (data_in_valid = 1), effects appear on the next clock edge (latency 1 cycle):
  - data_out[65:2] = bypass_enable ? r : d
  - data_out[1:0] = data_in[1:0]
  - data_out_valid = 1
  - s[k] <= r[63-k] for k = 0..57. The state always updates from the received scrambled bits, including in bypass, so leaving bypass needs no resync.
  - primed <= 1, and stays 1 until reset.
  - header_err = 1 if data_in[1:0] is 2'b00 or 2'b11, else 0.
- data_in_valid = 0:
  - data_out, s and primed hold.
  - data_out_valid = 0, header_err = 0.
  - data_in is ignored entirely, including its header.
- err_count:
  - Increments by 1 on each header_err event.
  - Saturates at 2^ERR_CNT_W - 1 and never wraps.
  - err_clear has priority: if an error and err_clear occur in the same cycle, the result is 0.
  - err_clear with no valid block still clears.
- The first block after reset is descrambled against an all-ones state. Its bits 0..57 are not meaningful against a real link; this is indicated only by primed = 0 at acceptance time (data_out of that block is emitted while primed is still 0).
- Reset mid-stream: the next cycle shows reset values exactly; any in-flight block is discarded.
- Back-to-back valid blocks: one block per clock, no bubbles, no backpressure.

Optional Feature:
DESCRAM_ERR_CNT_EN
- Defined: err_count and err_clear behave as above.
- Not defined:
  - The counter register is not built and err_count is driven constant 0.
  - err_clear is ignored.
  - header_err still pulses as specified.

Test Plan:
- Reset, then one valid block with payload 64'h0 and header 2'b01 → next cycle: data_out_valid = 1, data_out[65:2] = 64'h03FF_FF80_0000_0000, data_out[1:0] = 2'b01, primed = 1, header_err = 0.
- Continue with a second all-zero payload block → data_out[65:2] = 64'h0 (state is now all zeros).
- Loopback: drive the scrambler and this block from the same reset with 1000 random blocks (headers 01/10), bypass_enable = 0 → from the second block onward, descrambled payload and header equal the original scrambler input, with a two-cycle pipeline offset.
- Bypass: set bypass_enable = 1 for 3 blocks mid-stream → those payloads equal the raw r. The first block after returning bypass_enable to 0 is still correctly descrambled (state was tracked).
- Headers 2'b11, 2'b00, 2'b10 on consecutive valid cycles, ERR_CNT_W = 4 → header_err = 1,1,0 and err_count = 1,2,2. Then 20 more 2'b11 blocks → err_count = 15 (saturated). Then err_clear together with a 2'b00 block → err_count = 0.
- Gaps and reset: toggle data_in_valid low for 5 cycles while data_in changes, including header 2'b11 → outputs hold, data_out_valid = 0, no count change. Then assert reset for 1 cycle between two valid blocks → all outputs return to reset values, and the following block decodes against the all-ones state.
